// File: rtl/sr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to a 1-cycle
// latency instruction memory and buffers returned words for decode.
module sr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic [31:0]                imAddr,
  output logic                       imReq,
  input  logic [31:0]                imData,
  output logic [31:0]                instr_o,
  output logic [31:0]                pc_o,
  output logic [31:0]                pcPlus4_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetchPc;
  logic [31:0]   inflightPc;
  logic          inflight;
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic [CW:0]   credit;
  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   pcMem    [DEPTH];
  logic          push;
  logic          pop;
  logic          valid;

  // A request is allowed only if the queue can absorb every word already owed.
  assign credit = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imReq  = !rst && !redirect_i && (credit < (CW+1)'(DEPTH));
  assign imAddr = fetchPc;

  assign valid  = (count != '0);
  assign push   = inflight && !redirect_i;
  assign pop    = valid && ready_i && !redirect_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc    <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
    end else if (redirect_i) begin
      fetchPc  <= redirect_pc_i & ~32'h0000_0003;
      inflight <= 1'b0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
    end else begin
      inflight <= imReq;
      if (imReq) begin
        inflightPc <= fetchPc;
        fetchPc    <= fetchPc + 32'd4;
      end
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtr] <= imData;
      pcMem[wrPtr]    <= inflightPc;
    end
  end

  always_comb begin
    instr_o   = '0;
    pc_o      = '0;
    pcPlus4_o = '0;
    if (valid) begin
      instr_o   = instrMem[rdPtr];
      pc_o      = pcMem[rdPtr];
      pcPlus4_o = pcMem[rdPtr] + 32'd4;
    end
  end

  assign valid_o = valid;
  assign count_o = count;

endmodule

// File: tb/tb_sr_fetch_queue.sv
// Bench for sr_fetch_queue: directed scenarios plus random traffic, checked
// against a queue-based model of the fetch stage.
module tb_sr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imAddr;
  logic        imReq;
  logic [31:0] imData;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pcPlus4_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  count_o;

  sr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imAddr(imAddr), .imReq(imReq), .imData(imData), .instr_o(instr_o),
    .pc_o(pc_o), .pcPlus4_o(pcPlus4_o), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  // Model: the queue holds PCs; the instruction is a fixed function of the PC.
  logic [31:0] mFetch;
  logic [31:0] mInflPc;
  bit          mInfl;
  logic [31:0] mQ[$];
  logic        memReq;
  logic [31:0] memAddr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mFetch = RESET_PC;
    mInfl  = 1'b0;
    mQ.delete();
  endtask

  task automatic checkOutputs();
    bit expReq;
    expReq = !redirect_i && ((mQ.size() + int'(mInfl)) < DEPTH);
    chk("imReq", 32'(imReq), 32'(expReq));
    chk("imAddr", imAddr, mFetch);
    chk("count", 32'(count_o), mQ.size());
    chk("valid", 32'(valid_o), 32'(mQ.size() != 0));
    if (mQ.size() != 0) begin
      chk("pc", pc_o, mQ[0]);
      chk("instr", instr_o, memWord(mQ[0]));
      chk("pcPlus4", pcPlus4_o, mQ[0] + 32'd4);
    end else begin
      chk("pcEmpty", pc_o, 32'h0);
      chk("instrEmpty", instr_o, 32'h0);
      chk("pcPlus4Empty", pcPlus4_o, 32'h0);
    end
  endtask

  task automatic checkReset();
    chk("rstImReq", 32'(imReq), 32'h0);
    chk("rstValid", 32'(valid_o), 32'h0);
    chk("rstCount", 32'(count_o), 32'h0);
    chk("rstPc", pc_o, 32'h0);
    chk("rstInstr", instr_o, 32'h0);
    chk("rstPcPlus4", pcPlus4_o, 32'h0);
  endtask

  // One cycle: drive at negedge, check, advance model, clock, return memory data.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit doReq;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    ready_i       = rdy;
    #1;
    checkOutputs();
    memReq  = imReq;
    memAddr = imAddr;
    if (redir) begin
      mQ.delete();
      mInfl  = 1'b0;
      mFetch = rpc & ~32'h3;
    end else begin
      doReq = (mQ.size() + int'(mInfl)) < DEPTH;
      if (mQ.size() != 0 && rdy) void'(mQ.pop_front());
      if (mInfl) mQ.push_back(mInflPc);
      mInfl = doReq;
      if (doReq) begin
        mInflPc = mFetch;
        mFetch  = mFetch + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    imData = memReq ? memWord(memAddr) : $urandom;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0; imData = '0;
    memReq = 1'b0; memAddr = '0;
    modelReset();
    #1;
    checkReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Streaming after reset.
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

    // Decode frozen: queue fills to DEPTH and requests stop; then drain.
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);
    chk("satCount", 32'(count_o), 32'(DEPTH));
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

    // Redirect with a word in flight; target low bits ignored.
    step(1'b1, 32'h0000_0103, 1'b1);
    chk("redirCount", 32'(count_o), 32'h0);
    chk("redirAddr", imAddr, 32'h0000_0100);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Build count 2, then redirect coinciding with a pop.
    step(1'b1, 32'h0000_2000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    chk("preRedirCount", 32'(count_o), 32'h2);
    step(1'b1, 32'h0000_3000, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Back-to-back redirects, then PC wrap at the top of the address space.
    step(1'b1, 32'h0000_4444, 1'b1);
    step(1'b1, 32'hFFFF_FFF9, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

    // Asynchronous reset with count 3 and a fetch in flight.
    step(1'b1, 32'h0000_5000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    chk("preRstCount", 32'(count_o), 32'h3);
    #2 rst = 1'b1;
    #1 checkReset();
    @(posedge clk);
    #1 checkReset();
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit          rd;
      bit          rr;
      logic [31:0] tgt;
      rr  = ($urandom_range(0, 19) == 0);
      rd  = (i % 64 < 32) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tgt = $urandom;
      step(rr, tgt, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/sr_fetch_queue.md
Name: sr_fetch_queue

Overview:
Instruction fetch stage with a small prefetch queue, sitting directly upstream of the decode stage. It owns the fetch PC and issues word requests to the instruction memory, which has a 1-cycle read latency. Returned words are buffered with their PC and PC+4 and presented to decode through a valid/ready handshake. A redirect from the branch-resolution logic flushes the queue and any in-flight fetch, then restarts fetching at the target.

Parameters:
DEPTH  4  queue entries; power of two, minimum 2
RESET_PC  32'h0000_0000  first fetch address after reset

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-high reset
redirect_i  in  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced to 0)
imAddr  out  32  instruction memory word address (byte address, bits [1:0] = 0)
imReq  out  1  memory read request this cycle
imData  in  32  read data, valid the cycle after imReq was high
instr_o  out  32  head instruction
pc_o  out  32  PC of head instruction
pcPlus4_o  out  32  pc_o + 4, modulo 2^32
valid_o  out  1  head entry valid
ready_i  in  1  decode accepts head (includes decode freeze)
count_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (asynchronous, while rst=1):
  - fetch_pc = RESET_PC; count_o = 0; valid_o = 0; imReq = 0; inflight = 0; queue pointers = 0.
  - instr_o, pc_o and pcPlus4_o are 0 while the queue is empty.
- State:
  - fetch_pc: 32-bit fetch PC.
  - inflight: 1-bit flag; inflight_pc: 32 bits.
  - Circular buffer of DEPTH entries {instr, pc}, with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a count register.
- Request rule (combinational):
  - imReq = !rst && !redirect_i && (count + inflight) < DEPTH.
  - imAddr = fetch_pc.
  - On a posedge with imReq=1: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (wraps 32'hFFFF_FFFC -> 0).
  - Otherwise inflight <= 0.
- Push: when inflight=1 and no redirect, {imData, inflight_pc} is written at the write pointer and the pointer is incremented. The credit rule guarantees no push into a full queue.
- Pop: when valid_o && ready_i, the read pointer is incremented.
- Count: count <= count + push - pop. Simultaneous push and pop leaves count unchanged and is legal at any occupancy, including DEPTH-1.
- Outputs: valid_o = (count != 0). instr_o and pc_o are driven combinationally from the head entry. The earliest a fetched word can appear at the output is 2 cycles after its request edge: request edge, then data captured next edge, then visible.
- Redirect (takes priority over push, pop and request):
  - At that posedge: count <= 0, pointers <= 0, inflight <= 0 (the returning word is discarded), fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
  - imReq = 0 in the redirect cycle; fetching resumes on the next cycle.
  - valid_o = 0 from the cycle after the redirect until the first target word is pushed.
  - A pop in the redirect cycle is ignored and has no side effect.
- Back-to-back redirects: only the last one takes effect; each restarts the sequence.
- Reset asserted mid-operation clears everything immediately, regardless of the clock.
- A data word is never delivered twice and never skipped, except for words discarded by a redirect.

Test Plan:
- Reset, then ready_i=1 continuously -> imAddr sequence 0,4,8,...; first valid_o 2 cycles after rst falls with pc_o=0, pcPlus4_o=4; afterwards one instruction per cycle with pc_o increasing by 4.
- ready_i=0 held, DEPTH=4 -> exactly 4 requests issued (0,4,8,C), count_o saturates at 4, imReq stays 0; raise ready_i -> pops in order 0,4,8,C and fetch resumes at 0x10.
- Steady stream, redirect_i=1 with redirect_pc_i=32'h0000_0103 while one word is in flight -> in-flight word dropped, count_o=0 the next cycle, next imAddr=0x100, first valid output has pc_o=0x100.
- Redirect asserted in the same cycle as a pop at count_o=2 -> count_o=0 afterwards, no extra pop, no word from the old stream ever appears.
- Redirect to 32'hFFFF_FFF8 -> pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; pcPlus4_o=0 for the FFFF_FFFC entry.
- rst pulsed asynchronously (between clock edges) while count_o=3 and a fetch is in flight -> valid_o, imReq and count_o go to 0 immediately; after release, fetch restarts at RESET_PC.
